mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 147 ++++++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Registers the EX-to-MEM bus, then extracts and extends load data from the
// SRAM read port. The SRAM returns data only in the first cycle an
// instruction sits in this stage. A stalled load therefore keeps a private
// copy of that data, so its writeback value stays stable until it leaves.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id_fwd
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    logic [EX_TO_MEM_WD-1:0] r_pipe;
    logic                    r_first;
    logic [31:0]             r_hold;
    logic                    r_hold_valid;

    logic        w_stall_mem;
    logic        w_stall_wb;
    logic        w_bubble;
    logic        w_load_en;
    logic        w_is_load;
    logic        w_unused;

    logic [2:0]  w_mem_op;
    logic [31:0] w_pc;
    logic        w_data_ram_en;
    logic [3:0]  w_data_ram_wen;
    logic        w_sel_rf_res;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_ex_result;
    logic [1:0]  w_off;

    logic [31:0] w_src;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_rf_wdata;
    logic [69:0] w_wb_bus;

    // The MEM stage only looks at its own stall bit and the one behind it.
    assign w_stall_mem = stall[3];
    assign w_stall_wb  = stall[4];
    assign w_bubble    = w_stall_mem & ~w_stall_wb;
    assign w_load_en   = ~w_stall_mem;
    assign w_unused    = ^{stall[2:0], stall[STALL_WD-1:5]};

    assign w_mem_op       = r_pipe[78:76];
    assign w_pc           = r_pipe[75:44];
    assign w_data_ram_en  = r_pipe[43];
    assign w_data_ram_wen = r_pipe[42:39];
    assign w_sel_rf_res   = r_pipe[38];
    assign w_rf_we        = r_pipe[37];
    assign w_rf_waddr     = r_pipe[36:32];
    assign w_ex_result    = r_pipe[31:0];
    assign w_off          = w_ex_result[1:0];

    assign w_is_load = w_data_ram_en & (w_data_ram_wen == 4'b0000) & w_sel_rf_res;

    // Pipeline register: bubble wins over hold, load only when MEM is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else if (w_bubble) begin
            r_pipe <= '0;
        end else if (w_load_en) begin
            r_pipe <= ex_to_mem_bus;
        end
    end

    // First-cycle flag marks the one cycle the SRAM data belongs to us.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first <= 1'b0;
        end else begin
            r_first <= ~w_bubble & w_load_en;
        end
    end

    // Capture SRAM data when a load leaves its first cycle without moving on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_bubble || w_load_en) begin
            r_hold_valid <= 1'b0;
        end else if (r_first && w_is_load && !r_hold_valid) begin
            r_hold       <= data_sram_rdata;
            r_hold_valid <= 1'b1;
        end
    end

    assign w_src = r_hold_valid ? r_hold : data_sram_rdata;

    // Little-endian byte lane selection.
    always_comb begin
        w_byte = w_src[7:0];
        case (w_off)
            2'd0:    w_byte = w_src[7:0];
            2'd1:    w_byte = w_src[15:8];
            2'd2:    w_byte = w_src[23:16];
            default: w_byte = w_src[31:24];
        endcase
    end

    // Half-word lane selection; the low offset bit does not matter.
    always_comb begin
        w_half = w_off[1] ? w_src[31:16] : w_src[15:0];
    end

    // Sign/zero extension by load type; reserved encodings behave as LW.
    always_comb begin
        w_load_data = w_src;
        case (w_mem_op)
            OP_LW:   w_load_data = w_src;
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'b0, w_byte};
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {16'b0, w_half};
            default: w_load_data = w_src;
        endcase
    end

    // Writeback data selection between memory result and ALU result.
    always_comb begin
        w_rf_wdata = w_sel_rf_res ? w_load_data : w_ex_result;
    end

    assign w_wb_bus      = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_to_wb_bus = w_wb_bus;
    assign mem_to_id_fwd = {w_rf_we, w_rf_waddr, w_rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic for mem_stage,
// checked against a behavioural model of the stage kept in the bench.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [78:0] bus;
    logic [31:0] rdata;
    logic [69:0] wb;
    logic [37:0] fwd;

    int n_err = 0;
    int n_chk = 0;

    // Behavioural model: the instruction held in MEM and its captured data.
    logic [78:0] m_instr;
    logic        m_fresh;
    logic [31:0] m_saved;
    logic        m_saved_ok;

    always #5 clk = ~clk;

    mem_stage #(
        .EX_TO_MEM_WD(79),
        .MEM_TO_WB_WD(70),
        .STALL_WD    (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_to_mem_bus  (bus),
        .data_sram_rdata(rdata),
        .mem_to_wb_bus  (wb),
        .mem_to_id_fwd  (fwd)
    );

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [78:0] mk(input logic [2:0] op, input logic [31:0] pc,
                                       input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {op, pc, en, wen, sel, we, wa, res};
    endfunction

    function automatic logic [78:0] ld(input logic [2:0] op, input logic [4:0] wa,
                                       input logic [31:0] addr);
        return mk(op, 32'h0000_4000 + addr, 1'b1, 4'b0000, 1'b1, 1'b1, wa, addr);
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'h0000_00FF;
        h = (w >> (16 * off[1])) & 32'h0000_FFFF;
        case (op)
            3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic model_is_load(input logic [78:0] i);
        return i[43] && (i[42:39] == 4'd0) && i[38];
    endfunction

    function automatic logic [69:0] model_wb(input logic [31:0] rd);
        logic [31:0] src;
        logic [31:0] wd;
        src = m_saved_ok ? m_saved : rd;
        wd  = m_instr[38] ? load_value(m_instr[78:76], m_instr[1:0], src) : m_instr[31:0];
        return {m_instr[75:44], m_instr[37], m_instr[36:32], wd};
    endfunction

    function automatic logic [5:0] st(input logic [1:0] s43);
        return {1'b0, s43, 3'b000};
    endfunction

    // Apply inputs for one cycle and compare both outputs with the model.
    task automatic drive_check(input logic r, input logic [5:0] s, input logic [78:0] b,
                               input logic [31:0] rd);
        logic [69:0] exp;
        rst   = r;
        stall = s;
        bus   = b;
        rdata = rd;
        @(negedge clk);
        exp = model_wb(rd);
        check("wb_model", wb, exp);
        check("fwd_model", {32'b0, fwd}, {32'b0, exp[37:0]});
    endtask

    // Advance one clock and move the model with the same inputs.
    task automatic tick;
        @(posedge clk);
        if (rst) begin
            m_instr = '0; m_fresh = 1'b0; m_saved = '0; m_saved_ok = 1'b0;
        end else if (stall[3] && !stall[4]) begin
            m_instr = '0; m_fresh = 1'b0; m_saved_ok = 1'b0;
        end else if (!stall[3]) begin
            m_instr = bus; m_fresh = 1'b1; m_saved_ok = 1'b0;
        end else begin
            if (m_fresh && model_is_load(m_instr) && !m_saved_ok) begin
                m_saved = rdata; m_saved_ok = 1'b1;
            end
            m_fresh = 1'b0;
        end
        #1;
    endtask

    task automatic cyc(input logic r, input logic [5:0] s, input logic [78:0] b,
                       input logic [31:0] rd);
        drive_check(r, s, b, rd);
        tick();
    endtask

    logic [78:0] nop;
    logic [78:0] rb;
    logic [31:0] rr;

    initial begin
        m_instr = '0; m_fresh = 1'b0; m_saved = '0; m_saved_ok = 1'b0;
        nop = '0;
        rst = 1'b1; stall = '0; bus = '0; rdata = '0;

        // Reset state
        tick();
        cyc(1'b1, st(2'b00), ld(3'd0, 5'd9, 32'h44), 32'h1234_5678);
        drive_check(1'b0, st(2'b00), ld(3'd0, 5'd5, 32'h100), 32'h5555_0000);
        check("rst_wb", wb, 70'd0);
        check("rst_fwd", {32'b0, fwd}, 70'd0);
        tick();

        // LW then sub-word loads back to back
        drive_check(1'b0, st(2'b00), ld(3'd1, 5'd6, 32'h203), 32'hDEAD_BEEF);
        check("lw", wb[37:0], {1'b1, 5'd5, 32'hDEAD_BEEF});
        tick();
        drive_check(1'b0, st(2'b00), ld(3'd2, 5'd6, 32'h201), 32'h8081_F27F);
        check("lb_off3", wb[31:0], 32'hFFFF_FF80);
        tick();
        drive_check(1'b0, st(2'b00), ld(3'd3, 5'd6, 32'h202), 32'h8081_F27F);
        check("lbu_off1", wb[31:0], 32'h0000_00F2);
        tick();
        drive_check(1'b0, st(2'b00), ld(3'd4, 5'd6, 32'h200), 32'h8081_F27F);
        check("lh_off2", wb[31:0], 32'hFFFF_8081);
        tick();
        drive_check(1'b0, st(2'b00), nop, 32'h8081_F27F);
        check("lhu_off0", wb[31:0], 32'h0000_F27F);
        tick();

        // Stalled load keeps its first-cycle data
        cyc(1'b0, st(2'b00), ld(3'd0, 5'd7, 32'h300), 32'h0);
        drive_check(1'b0, st(2'b11), ld(3'd1, 5'd1, 32'h1), 32'h1122_3344);
        check("stall_c1", wb[31:0], 32'h1122_3344);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive_check(1'b0, st(2'b11), ld(3'd1, 5'd1, 32'h1), 32'hAAAA_AAAA);
            check("stall_hold", wb[31:0], 32'h1122_3344);
            tick();
        end
        drive_check(1'b0, st(2'b00), nop, 32'hAAAA_AAAA);
        check("stall_release", wb[31:0], 32'h1122_3344);
        tick();

        // Bubble after a pending ALU op
        cyc(1'b0, st(2'b00), mk(3'd0, 32'h500, 1'b0, 4'd0, 1'b0, 1'b1, 5'd9, 32'h7), 32'h0);
        drive_check(1'b0, st(2'b01), ld(3'd0, 5'd2, 32'h8), 32'h0);
        check("alu_before_bubble", wb[37:0], {1'b1, 5'd9, 32'h7});
        tick();
        drive_check(1'b0, st(2'b00), nop, 32'hFFFF_FFFF);
        check("bubble_wb", wb, 70'd0);
        check("bubble_fwd_we", {69'b0, fwd[37]}, 70'd0);
        tick();

        // ALU result ignores SRAM data
        cyc(1'b0, st(2'b00), mk(3'd1, 32'h600, 1'b0, 4'd0, 1'b0, 1'b1, 5'd4, 32'h1234_5678), 32'h0);
        drive_check(1'b0, st(2'b00), nop, $urandom);
        check("alu_wdata", wb[31:0], 32'h1234_5678);
        tick();

        // Reset during a stalled load with captured data
        cyc(1'b0, st(2'b00), ld(3'd0, 5'd3, 32'h700), 32'h0);
        cyc(1'b0, st(2'b11), nop, 32'h5555_5555);
        drive_check(1'b1, st(2'b11), nop, 32'h6666_6666);
        check("held_before_rst", wb[31:0], 32'h5555_5555);
        tick();
        drive_check(1'b0, st(2'b00), ld(3'd0, 5'd5, 32'h100), 32'h7777_7777);
        check("rst_mid_wb", wb, 70'd0);
        check("rst_mid_fwd", {32'b0, fwd}, 70'd0);
        check("rst_mid_hold_valid", {69'b0, dut.r_hold_valid}, 70'd0);
        tick();
        drive_check(1'b0, st(2'b00), nop, 32'hDEAD_BEEF);
        check("lw_after_rst", wb[37:0], {1'b1, 5'd5, 32'hDEAD_BEEF});
        tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rb = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                rb[43] = 1'b1; rb[42:39] = 4'd0; rb[38] = 1'b1;
            end
            rr = $urandom;
            drive_check(($urandom_range(0, 39) == 0), 6'($urandom), rb, rr);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
